// File: rtl/axil_master_arbiter.sv
// Two-client round-robin arbiter that drives one AXI4-Lite master port.
// One transaction is in flight at a time; every output comes from a flop.
module axil_master_arbiter #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     c0_req,
    input  logic                     c0_we,
    input  logic [ADDR_WIDTH-1:0]    c0_addr,
    input  logic [DATA_WIDTH-1:0]    c0_wdata,
    output logic                     c0_done,
    input  logic                     c1_req,
    input  logic                     c1_we,
    input  logic [ADDR_WIDTH-1:0]    c1_addr,
    input  logic [DATA_WIDTH-1:0]    c1_wdata,
    output logic                     c1_done,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic [1:0]               rsp_resp,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    output logic [ADDR_WIDTH-1:0]    m_awaddr,
    output logic                     m_awvalid,
    input  logic                     m_awready,
    output logic [DATA_WIDTH-1:0]    m_wdata,
    output logic [DATA_WIDTH/8-1:0]  m_wstrb,
    output logic                     m_wvalid,
    input  logic                     m_wready,
    input  logic [1:0]               m_bresp,
    input  logic                     m_bvalid,
    output logic                     m_bready,
    output logic [ADDR_WIDTH-1:0]    m_araddr,
    output logic                     m_arvalid,
    input  logic                     m_arready,
    input  logic [DATA_WIDTH-1:0]    m_rdata,
    input  logic [1:0]               m_rresp,
    input  logic                     m_rvalid,
    output logic                     m_rready
);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE
    } state_t;

    state_t                   state_q;
    logic                     last_grant_q;
    logic                     gnt_q;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic                     awvalid_q;
    logic                     wvalid_q;
    logic                     bready_q;
    logic                     arvalid_q;
    logic                     rready_q;
    logic                     c0_done_q;
    logic                     c1_done_q;
    logic [DATA_WIDTH-1:0]    rdata_q;
    logic [1:0]               resp_q;
    logic [ERR_CNT_WIDTH-1:0] err_q;

    logic                     pick1_d;
    logic                     sel_we_d;
    logic                     aw_ok_d;
    logic                     w_ok_d;
    logic [1:0]               cap_resp_d;
    logic                     err_inc_d;

    // Arbitration choice, handshake completion and error detection
    always_comb begin
        pick1_d    = c1_req && (!c0_req || !last_grant_q);
        sel_we_d   = pick1_d ? c1_we : c0_we;
        aw_ok_d    = !awvalid_q || m_awready;
        w_ok_d     = !wvalid_q || m_wready;
        cap_resp_d = (state_q == WR_RESP) ? m_bresp : m_rresp;
        err_inc_d  = (cap_resp_d != 2'b00) && (err_q != '1);
    end

    // Transaction sequencer with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            c0_done_q    <= 1'b0;
            c1_done_q    <= 1'b0;
            rdata_q      <= '0;
            resp_q       <= 2'b00;
            err_q        <= '0;
        end else begin
            c0_done_q <= 1'b0;
            c1_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (c0_req || c1_req) begin
                        gnt_q        <= pick1_d;
                        last_grant_q <= pick1_d;
                        addr_q       <= pick1_d ? c1_addr : c0_addr;
                        wdata_q      <= pick1_d ? c1_wdata : c0_wdata;
                        if (sel_we_d) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WR_ADDR_DATA;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= RD_ADDR;
                        end
                    end
                end
                WR_ADDR_DATA: begin
                    if (awvalid_q && m_awready) awvalid_q <= 1'b0;
                    if (wvalid_q && m_wready)   wvalid_q  <= 1'b0;
                    if (aw_ok_d && w_ok_d) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_bvalid) begin
                        resp_q    <= m_bresp;
                        bready_q  <= 1'b0;
                        c0_done_q <= !gnt_q;
                        c1_done_q <= gnt_q;
                        if (err_inc_d) err_q <= err_q + ERR_CNT_WIDTH'(1);
                        state_q   <= DONE;
                    end
                end
                RD_ADDR: begin
                    if (m_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_rvalid) begin
                        rdata_q   <= m_rdata;
                        resp_q    <= m_rresp;
                        rready_q  <= 1'b0;
                        c0_done_q <= !gnt_q;
                        c1_done_q <= gnt_q;
                        if (err_inc_d) err_q <= err_q + ERR_CNT_WIDTH'(1);
                        state_q   <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign c0_done   = c0_done_q;
    assign c1_done   = c1_done_q;
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;
    assign err_cnt   = err_q;
    assign m_awaddr  = addr_q;
    assign m_awvalid = awvalid_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = '1;
    assign m_wvalid  = wvalid_q;
    assign m_bready  = bready_q;
    assign m_araddr  = addr_q;
    assign m_arvalid = arvalid_q;
    assign m_rready  = rready_q;

endmodule

// File: tb/tb_axil_master_arbiter.sv
// Directed bench for axil_master_arbiter with a reactive AXI-Lite slave
// and a scoreboard of expected completions.
module tb_axil_master_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int ERRW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            c0_req = 0, c0_we = 0;
    logic [AW-1:0]   c0_addr = '0;
    logic [DW-1:0]   c0_wdata = '0;
    logic            c0_done;
    logic            c1_req = 0, c1_we = 0;
    logic [AW-1:0]   c1_addr = '0;
    logic [DW-1:0]   c1_wdata = '0;
    logic            c1_done;
    logic [DW-1:0]   rsp_rdata;
    logic [1:0]      rsp_resp;
    logic [ERRW-1:0] err_cnt;
    logic [AW-1:0]   m_awaddr, m_araddr;
    logic            m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic [DW-1:0]   m_wdata;
    logic [DW/8-1:0] m_wstrb;

    // slave configuration driven by the stimulus
    logic            aw_rdy = 1, w_rdy = 1, ar_rdy = 1, b_hold = 0;
    logic [1:0]      bresp_cfg = 0, rresp_cfg = 0;
    logic [DW-1:0]   rdata_cfg = '0;
    logic            s_bvalid, s_rvalid, aw_got, w_got;
    logic [AW-1:0]   s_awaddr;
    logic [DW-1:0]   s_wdata;
    int              b_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          c;
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
        logic [ERRW-1:0] err;
    } exp_t;
    exp_t            q[$];
    logic [DW-1:0]   mdl_rdata = '0;
    logic [ERRW-1:0] mdl_err = '0;

    axil_master_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ERR_CNT_WIDTH(ERRW)
    ) dut (
        .clk(clk), .rst(rst),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr),
        .c0_wdata(c0_wdata), .c0_done(c0_done),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr),
        .c1_wdata(c1_wdata), .c1_done(c1_done),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_cnt(err_cnt),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(aw_rdy),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid),
        .m_wready(w_rdy),
        .m_bresp(bresp_cfg), .m_bvalid(s_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(ar_rdy),
        .m_rdata(rdata_cfg), .m_rresp(rresp_cfg), .m_rvalid(s_rvalid),
        .m_rready(m_rready)
    );

    always #5 clk = ~clk;

    // Slave: raise B once both AW and W are taken, raise R after AR
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s_bvalid <= 0; s_rvalid <= 0; aw_got <= 0; w_got <= 0;
            s_awaddr <= '0; s_wdata <= '0; b_cnt <= 0;
        end else begin
            logic aw_n, w_n;
            aw_n = aw_got || (m_awvalid && aw_rdy);
            w_n  = w_got || (m_wvalid && w_rdy);
            if (m_awvalid && aw_rdy) s_awaddr <= m_awaddr;
            if (m_wvalid && w_rdy)   s_wdata  <= m_wdata;
            if (aw_n && w_n && !s_bvalid && !b_hold) begin
                s_bvalid <= 1; aw_got <= 0; w_got <= 0;
            end else begin
                aw_got <= aw_n; w_got <= w_n;
            end
            if (s_bvalid && m_bready) begin
                s_bvalid <= 0; b_cnt <= b_cnt + 1;
            end
            if (m_arvalid && ar_rdy) s_rvalid <= 1;
            if (s_rvalid && m_rready) s_rvalid <= 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done pulse pops one expected completion
    always @(negedge clk) begin
        if (!rst && (c0_done || c1_done)) begin
            chk("one_done", {62'd0, c0_done, c1_done} == 64'd3, 0);
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_client", c1_done, e.c);
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_resp", rsp_resp, e.resp);
                chk("err_cnt", err_cnt, e.err);
            end
        end
    end

    task automatic issue(input logic c, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (!c) begin
            c0_req = 1; c0_we = we; c0_addr = a; c0_wdata = d;
        end else begin
            c1_req = 1; c1_we = we; c1_addr = a; c1_wdata = d;
        end
    endtask

    task automatic drop(input logic c);
        if (!c) c0_req = 0;
        else    c1_req = 0;
    endtask

    task automatic push(input logic c, input logic we);
        logic [1:0] r;
        r = we ? bresp_cfg : rresp_cfg;
        if (!we) mdl_rdata = rdata_cfg;
        if (r != 2'b00 && mdl_err != '1) mdl_err = mdl_err + 1'b1;
        q.push_back('{c, mdl_rdata, r, mdl_err});
    endtask

    task automatic wait_done(input logic c, output int cyc);
        cyc = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if ((!c && c0_done) || (c && c1_done)) begin
                cyc = i;
                break;
            end
        end
        chk("done_timeout", cyc != 0, 1);
    endtask

    initial begin
        int cyc;
        logic [ERRW-1:0] exp_err[6];
        exp_err = '{1, 2, 3, 3, 3, 3};

        // reset state
        @(negedge clk);
        chk("rst_awvalid", m_awvalid, 0);
        chk("rst_wvalid", m_wvalid, 0);
        chk("rst_arvalid", m_arvalid, 0);
        chk("rst_readies", {m_bready, m_rready}, 0);
        chk("rst_done", {c0_done, c1_done}, 0);
        chk("rst_rsp", {rsp_rdata, rsp_resp, err_cnt}, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        // single write, slave always ready
        push(0, 1);
        issue(0, 1, 32'h600, 32'hDEADBEEF);
        @(negedge clk);
        chk("wr_awvalid", m_awvalid, 1);
        chk("wr_wvalid", m_wvalid, 1);
        chk("wr_awaddr", m_awaddr, 32'h600);
        chk("wr_wdata", m_wdata, 32'hDEADBEEF);
        chk("wr_wstrb", m_wstrb, 4'hF);
        wait_done(0, cyc);
        drop(0);
        chk("wr_latency", cyc, 2);
        chk("wr_slave_addr", s_awaddr, 32'h600);
        chk("wr_slave_data", s_wdata, 32'hDEADBEEF);
        chk("wr_bcnt", b_cnt, 1);
        @(negedge clk);

        // read with AR stalled for three cycles
        ar_rdy = 0;
        rdata_cfg = 32'h12345678;
        push(1, 0);
        issue(1, 0, 32'h700, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rd_arvalid_held", m_arvalid, 1);
            chk("rd_araddr_stable", m_araddr, 32'h700);
            chk("rd_rready_low", m_rready, 0);
        end
        ar_rdy = 1;
        wait_done(1, cyc);
        drop(1);
        chk("rd_rdata", rsp_rdata, 32'h12345678);
        @(negedge clk);

        // contention: both clients keep requesting
        rdata_cfg = 32'hA5A5A5A5;
        push(0, 1); push(1, 0); push(0, 1); push(1, 0);
        issue(0, 1, 32'h800, 32'h11111111);
        issue(1, 0, 32'h900, '0);
        for (int i = 0; i < 4; i++) begin
            wait_done(i[0], cyc);
            if (i == 3) begin
                drop(0); drop(1);
            end
        end
        @(negedge clk);

        // split AW/W handshakes
        cyc = b_cnt;
        aw_rdy = 1; w_rdy = 0;
        push(0, 1);
        issue(0, 1, 32'h604, 32'hCAFEF00D);
        @(negedge clk);
        chk("split_both_valid", {m_awvalid, m_wvalid}, 2'b11);
        @(negedge clk);
        chk("split_aw_dropped", m_awvalid, 0);
        chk("split_w_held", m_wvalid, 1);
        chk("split_bready_low", m_bready, 0);
        @(negedge clk);
        chk("split_aw_stays_low", m_awvalid, 0);
        chk("split_w_still", m_wvalid, 1);
        w_rdy = 1;
        begin
            int b0;
            b0 = cyc;
            wait_done(0, cyc);
            drop(0);
            @(negedge clk);
            @(negedge clk);
            chk("split_one_b", b_cnt, b0 + 1);
        end
        chk("split_slave_data", s_wdata, 32'hCAFEF00D);

        // error responses saturate the counter
        rresp_cfg = 2'b10;
        rdata_cfg = 32'h0BAD0BAD;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) rresp_cfg = 2'b00;
            push(1, 0);
            issue(1, 0, 32'h700 + i, '0);
            wait_done(1, cyc);
            drop(1);
            chk("err_sat", err_cnt, exp_err[i]);
            @(negedge clk);
        end

        // reset while waiting for B
        b_hold = 1;
        issue(0, 1, 32'h610, 32'h55AA55AA);
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_bready) begin
                cyc = 1;
                break;
            end
        end
        chk("reach_wr_resp", cyc, 1);
        #2 rst = 1;
        #1;
        chk("arst_valids", {m_awvalid, m_wvalid, m_arvalid}, 0);
        chk("arst_readies", {m_bready, m_rready}, 0);
        chk("arst_err", err_cnt, 0);
        chk("arst_done", {c0_done, c1_done}, 0);
        drop(0);
        mdl_err = '0;
        mdl_rdata = '0;
        b_hold = 0;
        rresp_cfg = 2'b00;
        rdata_cfg = 32'h77;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        // tie after reset goes to client 0
        push(0, 0); push(1, 0);
        issue(0, 0, 32'hA00, '0);
        issue(1, 0, 32'hB00, '0);
        @(negedge clk);
        chk("tie_grant_c0", m_araddr, 32'hA00);
        wait_done(0, cyc);
        drop(0);
        wait_done(1, cyc);
        drop(1);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        chk("sb_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
